// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer and decoder.
package seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL,
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI
    } opcode_t;

    localparam int DEF_OPCODE_IMM_FIRST = 6;
    localparam int DEF_OPCODE_LAST      = 10;

    localparam int OPC_LSB = 12;
    localparam int RC_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;

    function automatic logic [3:0] field(input logic [15:0] w, input int lsb);
        return w[lsb +: 4];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: classifies an opcode as immediate-format and/or legal.
module instr_decoder
    import seq_pkg::*;
#(
    parameter int OPCODE_IMM_FIRST = DEF_OPCODE_IMM_FIRST,
    parameter int OPCODE_LAST      = DEF_OPCODE_LAST
) (
    input  logic [3:0] opcode,
    output logic       is_imm,
    output logic       is_legal
);

    localparam logic [3:0] IMM_FIRST = 4'(OPCODE_IMM_FIRST);
    localparam logic [3:0] LAST      = 4'(OPCODE_LAST);

    assign is_legal = opcode <= LAST;
    assign is_imm   = is_legal && (opcode >= IMM_FIRST);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle DECODE/EXEC/WB control sequencer for the
// register-bank/ALU datapath, fed one instruction at a time by valid/ready.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int READ_LATENCY     = 1,
    parameter int ALU_LATENCY      = 1,
    parameter int OPCODE_IMM_FIRST = DEF_OPCODE_IMM_FIRST,
    parameter int OPCODE_LAST      = DEF_OPCODE_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    output logic        instr_ready,
    output logic [3:0]  reg_a_addr,
    output logic [3:0]  reg_b_addr,
    output logic [3:0]  reg_c_addr,
    output logic [15:0] imm_out,
    output logic        imm_sel,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    input  logic [15:0] alu_result,
    output logic [15:0] last_result,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [3:0] RL_M1 = 4'(READ_LATENCY - 1);
    localparam logic [3:0] AL_M1 = 4'(ALU_LATENCY - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       legal_q;
    logic       dec_imm, dec_legal;
    logic [3:0] ra;

    assign ra = field(instr_in, RA_LSB);

    instr_decoder #(
        .OPCODE_IMM_FIRST(OPCODE_IMM_FIRST),
        .OPCODE_LAST     (OPCODE_LAST)
    ) u_dec (
        .opcode  (field(instr_in, OPC_LSB)),
        .is_imm  (dec_imm),
        .is_legal(dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts down the remaining cycles of the current DECODE or EXEC phase
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        instr_ready = 1'b0;
        reg_write   = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_n = S_DECODE;
                    cnt_n   = RL_M1;
                end
            end
            S_DECODE: begin
                if (!legal_q) state_n = S_IDLE;
                else if (cnt == 4'd0) begin
                    state_n = S_EXEC;
                    cnt_n   = AL_M1;
                end else cnt_n = cnt - 4'd1;
            end
            S_EXEC: begin
                if (cnt == 4'd0) state_n = S_WB;
                else cnt_n = cnt - 4'd1;
            end
            S_WB: begin
                reg_write = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        done = reg_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a_addr  <= '0;
            reg_b_addr  <= '0;
            reg_c_addr  <= '0;
            imm_out     <= '0;
            imm_sel     <= 1'b0;
            alu_op      <= '0;
            legal_q     <= 1'b0;
            illegal     <= 1'b0;
            last_result <= '0;
            instr_count <= '0;
        end else begin
            if (instr_ready && instr_valid) begin
                reg_a_addr <= dec_imm ? 4'd0 : ra;
                reg_b_addr <= field(instr_in, RB_LSB);
                reg_c_addr <= field(instr_in, RC_LSB);
                imm_out    <= dec_imm ? {12'b0, ra} : 16'd0;
                imm_sel    <= dec_imm;
                alu_op     <= field(instr_in, OPC_LSB);
                legal_q    <= dec_legal;
            end
            if (state == S_DECODE && !legal_q) illegal <= 1'b1;
            if (state == S_WB) begin
                last_result <= alu_result;
                instr_count <= instr_count + 16'd1;
                illegal     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: occupancy-based reference model plus directed and random stimulus.
module tb_instr_sequencer;

    localparam int OCC = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic instr_valid = 1'b0;
    logic [15:0] instr_in = '0, alu_result = '0;
    logic instr_ready, imm_sel, reg_write, done, illegal;
    logic [3:0] reg_a_addr, reg_b_addr, reg_c_addr, alu_op;
    logic [15:0] imm_out, last_result, instr_count;

    logic v2 = 1'b0;
    logic [15:0] i2 = '0;
    logic ready2, imm_sel2, rw2, done2, ill2;
    logic [3:0] a2, b2, c2, op2;
    logic [15:0] imm2, last2, cnt2;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
        .reg_c_addr(reg_c_addr), .imm_out(imm_out), .imm_sel(imm_sel), .alu_op(alu_op),
        .reg_write(reg_write), .alu_result(alu_result), .last_result(last_result),
        .done(done), .illegal(illegal), .instr_count(instr_count)
    );

    instr_sequencer #(.READ_LATENCY(3), .ALU_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .instr_valid(v2), .instr_in(i2),
        .instr_ready(ready2), .reg_a_addr(a2), .reg_b_addr(b2),
        .reg_c_addr(c2), .imm_out(imm2), .imm_sel(imm_sel2), .alu_op(op2),
        .reg_write(rw2), .alu_result(16'h5A5A), .last_result(last2),
        .done(done2), .illegal(ill2), .instr_count(cnt2)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit op_legal(input logic [15:0] w);
        return w[15:12] <= 4'd10;
    endfunction

    function automatic bit op_imm(input logic [15:0] w);
        return w[15:12] >= 4'd6 && w[15:12] <= 4'd10;
    endfunction

    // Model: busy = cycles of occupancy left for the instruction in flight
    int busy = 0;
    logic [15:0] mw = '0, m_cnt = '0, m_last = '0;
    logic m_ill = 1'b0;
    logic preload = 1'b0;
    bit exp_rw;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy = 0; m_cnt = '0; m_last = '0; m_ill = 1'b0;
        end else begin
            if (preload) m_cnt = 16'hFFFF;
            if (busy == 0) begin
                if (instr_valid) begin
                    mw = instr_in;
                    busy = op_legal(instr_in) ? OCC : 1;
                end
            end else begin
                if (busy == 1) begin
                    if (op_legal(mw)) begin
                        m_cnt = m_cnt + 16'd1; m_last = alu_result; m_ill = 1'b0;
                    end else m_ill = 1'b1;
                end
                busy--;
            end
        end
    end

    always @(negedge clk) begin
        exp_rw = busy == 1 && op_legal(mw);
        chk("instr_ready", instr_ready, busy == 0);
        chk("reg_write", reg_write, exp_rw);
        chk("done", done, exp_rw);
        if (!preload) chk("instr_count", instr_count, m_cnt);
        chk("last_result", last_result, m_last);
        chk("illegal", illegal, m_ill);
        if (busy > 0) begin
            chk("reg_c_addr", reg_c_addr, mw[11:8]);
            chk("reg_b_addr", reg_b_addr, mw[3:0]);
            chk("alu_op", alu_op, mw[15:12]);
            chk("imm_sel", imm_sel, op_imm(mw));
            chk("reg_a_addr", reg_a_addr, op_imm(mw) ? 4'd0 : mw[7:4]);
            if (op_imm(mw)) chk("imm_out", imm_out, {12'b0, mw[7:4]});
        end
    end

    int cyc = 0;
    int rw_times[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) if (reg_write) rw_times.push_back(cyc);

    task automatic issue(input logic [15:0] w);
        int k = 0;
        instr_valid = 1'b1;
        instr_in = w;
        while (!instr_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (k == 20) chk("accept_timeout", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_rw(output int n);
        n = 0;
        while (!reg_write && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_rw", reg_write, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_a", reg_a_addr, 0);
        chk("rst_imm", imm_out, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_illegal", illegal, 0);
        reset = 1'b0;

        alu_result = 16'h00A5;
        issue(16'h0312);
        wait_rw(n);
        chk("rtype_lat", n, 2);
        chk("rtype_a", reg_a_addr, 1);
        chk("rtype_b", reg_b_addr, 2);
        chk("rtype_c", reg_c_addr, 3);
        chk("rtype_op", alu_op, 0);
        chk("rtype_imm_sel", imm_sel, 0);
        chk("rtype_done", done, 1);
        @(posedge clk); #1;
        chk("rtype_rw_once", reg_write, 0);
        chk("rtype_last", last_result, 16'h00A5);
        chk("rtype_count", instr_count, 1);
        chk("rtype_ready", instr_ready, 1);

        alu_result = 16'h1234;
        issue(16'h6A95);
        wait_rw(n);
        chk("imm_out", imm_out, 16'h0009);
        chk("imm_sel", imm_sel, 1);
        chk("imm_b", reg_b_addr, 5);
        chk("imm_c", reg_c_addr, 4'hA);
        chk("imm_a", reg_a_addr, 0);
        chk("imm_done", done, 1);
        @(posedge clk); #1;
        chk("imm_rw_once", reg_write, 0);
        chk("imm_count", instr_count, 2);

        rw_times.delete();
        instr_valid = 1'b1;
        instr_in = 16'h0123;
        @(posedge clk); #1;
        instr_in = 16'h0456;
        k = 0;
        while (!instr_ready && k < 10) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_pulses", rw_times.size(), 2);
        if (rw_times.size() == 2) chk("busy_spacing", rw_times[1] - rw_times[0], 4);
        chk("busy_count", instr_count, 4);

        issue(16'hC123);
        chk("ill_busy", instr_ready, 0);
        @(posedge clk); #1;
        chk("ill_flag", illegal, 1);
        chk("ill_idle", instr_ready, 1);
        chk("ill_count", instr_count, 4);
        issue(16'h1000);
        wait_rw(n);
        @(posedge clk); #1;
        chk("ill_clear", illegal, 0);
        chk("ill_next_count", instr_count, 5);

        force dut.instr_count = 16'hFFFF;
        preload = 1'b1;
        @(posedge clk); #1;
        release dut.instr_count;
        preload = 1'b0;
        chk("preload", instr_count, 16'hFFFF);
        issue(16'h2345);
        wait_rw(n);
        @(posedge clk); #1;
        chk("wrap", instr_count, 0);

        alu_result = 16'hBEEF;
        issue(16'h0312);
        wait_rw(n);
        #2 reset = 1'b1;
        #1;
        chk("abort_rw", reg_write, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_count", instr_count, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_last", last_result, 0);

        v2 = 1'b1;
        i2 = 16'h0312;
        @(posedge clk); #1;
        v2 = 1'b0;
        n = 0;
        while (!rw2 && n < 40) begin @(posedge clk); #1; n++; end
        chk("lat2_rw", n, 5);
        chk("lat2_done", done2, 1);
        @(posedge clk); #1;
        chk("lat2_rw_once", rw2, 0);
        chk("lat2_ready", ready2, 1);
        chk("lat2_count", cnt2, 1);
        chk("lat2_last", last2, 16'h5A5A);

        repeat (400) begin
            @(posedge clk); #1;
            instr_valid = 1'($urandom_range(0, 1));
            instr_in = 16'($urandom);
            alu_result = 16'($urandom);
        end
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
